// File: rtl/neuron_event_scheduler_if.sv
// Purpose : bundles the AER/request inputs, SRAM strobes and spike outputs of the event scheduler.
// Latency : none, signal container only.
// Backpressure: AER uses valid/ready; time-step and reset requests are single-cycle pulses.
// Ports   : slave = scheduler side (drives strobes, spikes, aer_ready),
//           master = upstream/core side (drives spikes in, requests, core spike flags).
interface neuron_event_scheduler_if #(
   parameter int OUTPUT_NEURON        = 256,
   parameter int POST_NEUR_PARALLEL   = 4,
   parameter int PRE_NEUR_ADDR_WIDTH  = 10,
   parameter int POST_NEUR_ADDR_WIDTH = 10,
   parameter int SYN_ARRAY_ADDR_WIDTH = 16
);
   localparam int GROUPS = OUTPUT_NEURON / POST_NEUR_PARALLEL;
   localparam int GW     = $clog2(GROUPS);

   logic                            aer_valid;
   logic [PRE_NEUR_ADDR_WIDTH-1:0]  aer_addr;
   logic                            aer_ready;
   logic                            tstep_req;
   logic                            tref_req;
   logic [POST_NEUR_PARALLEL-1:0]   neur_event_out;
   logic [PRE_NEUR_ADDR_WIDTH-1:0]  ctrl_pre_neuron_address;
   logic [POST_NEUR_ADDR_WIDTH-1:0] ctrl_post_neuron_address;
   logic                            ctrl_pre_neur_cs;
   logic                            ctrl_pre_neur_we;
   logic                            ctrl_post_neur_cs;
   logic                            ctrl_post_neur_we;
   logic                            ctrl_pre_cnt_en;
   logic                            ctrl_neur_event;
   logic                            ctrl_tstep_event;
   logic                            ctrl_tref_event;
   logic [SYN_ARRAY_ADDR_WIDTH-1:0] syn_addr;
   logic                            spike_valid;
   logic [POST_NEUR_PARALLEL-1:0]   spike_mask;
   logic [GW-1:0]                   spike_group;
   logic                            busy;

   modport slave (
      input  aer_valid, aer_addr, tstep_req, tref_req, neur_event_out,
      output aer_ready, ctrl_pre_neuron_address, ctrl_post_neuron_address,
             ctrl_pre_neur_cs, ctrl_pre_neur_we, ctrl_post_neur_cs, ctrl_post_neur_we,
             ctrl_pre_cnt_en, ctrl_neur_event, ctrl_tstep_event, ctrl_tref_event,
             syn_addr, spike_valid, spike_mask, spike_group, busy
   );

   modport master (
      output aer_valid, aer_addr, tstep_req, tref_req, neur_event_out,
      input  aer_ready, ctrl_pre_neuron_address, ctrl_post_neuron_address,
             ctrl_pre_neur_cs, ctrl_pre_neur_we, ctrl_post_neur_cs, ctrl_post_neur_we,
             ctrl_pre_cnt_en, ctrl_neur_event, ctrl_tstep_event, ctrl_tref_event,
             syn_addr, spike_valid, spike_mask, spike_group, busy
   );
endinterface

// File: rtl/neuron_event_scheduler.sv
// Purpose : sequences pre-counter / post-state SRAM sweeps for AER spikes, time steps and resets.
// Latency : AER 2+2*GROUPS cycles, TSTEP 2*GROUPS, TREF INPUT_NEURON+2*GROUPS; spikes out 1 cycle after WR.
// Backpressure: aer_ready only in IDLE with no pending request; TSTEP/TREF pulses held as sticky flags.
// Ports   : clk_i, rst_n_i (async active-low), bus (slave modport of neuron_event_scheduler_if).
module neuron_event_scheduler #(
   parameter int INPUT_NEURON         = 784,
   parameter int OUTPUT_NEURON        = 256,
   parameter int POST_NEUR_PARALLEL   = 4,
   parameter int PRE_NEUR_ADDR_WIDTH  = 10,
   parameter int POST_NEUR_ADDR_WIDTH = 10,
   parameter int SYN_ARRAY_ADDR_WIDTH = 16
) (
   input logic                     clk_i,
   input logic                     rst_n_i,
   neuron_event_scheduler_if.slave bus
);
   localparam int GROUPS = OUTPUT_NEURON / POST_NEUR_PARALLEL;
   localparam int GW     = $clog2(GROUPS);
   localparam int BW     = $clog2(POST_NEUR_PARALLEL);

   typedef enum logic [3:0] {
      S_IDLE, S_PRE_RD, S_PRE_WR, S_POST_RD, S_POST_WR,
      S_TS_RD, S_TS_WR, S_TR_PRE, S_TR_RD, S_TR_WR
   } state_t;

   state_t                          state_q, state_d;
   logic [PRE_NEUR_ADDR_WIDTH-1:0]  addr_q, addr_d;
   logic [PRE_NEUR_ADDR_WIDTH-1:0]  pre_cnt_q, pre_cnt_d;
   logic [GW-1:0]                   grp_q, grp_d;
   logic                            tstep_pend_q, tstep_pend_d;
   logic                            tref_pend_q, tref_pend_d;
   logic                            out_en_q;
   logic                            spike_valid_q, spike_valid_d;
   logic [POST_NEUR_PARALLEL-1:0]   spike_mask_q, spike_mask_d;
   logic [GW-1:0]                   spike_group_q, spike_group_d;

   logic last_grp, last_pre, aer_ready, capture;

   assign last_grp = (grp_q == GW'(GROUPS - 1));
   assign last_pre = (pre_cnt_q == PRE_NEUR_ADDR_WIDTH'(INPUT_NEURON - 1));
   // out_en_q keeps aer_ready low while reset is asserted and rises on the first clock after release.
   assign aer_ready = out_en_q && (state_q == S_IDLE) && !tstep_pend_q && !tref_pend_q;
   // Reset sweeps never report spikes, only the synaptic and time-step write cycles do.
   assign capture = ((state_q == S_POST_WR) || (state_q == S_TS_WR)) && (|bus.neur_event_out);

   // State and datapath registers
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q       <= S_IDLE;
         addr_q        <= '0;
         pre_cnt_q     <= '0;
         grp_q         <= '0;
         tstep_pend_q  <= 1'b0;
         tref_pend_q   <= 1'b0;
         out_en_q      <= 1'b0;
         spike_valid_q <= 1'b0;
         spike_mask_q  <= '0;
         spike_group_q <= '0;
      end else begin
         state_q       <= state_d;
         addr_q        <= addr_d;
         pre_cnt_q     <= pre_cnt_d;
         grp_q         <= grp_d;
         tstep_pend_q  <= tstep_pend_d;
         tref_pend_q   <= tref_pend_d;
         out_en_q      <= 1'b1;
         spike_valid_q <= spike_valid_d;
         spike_mask_q  <= spike_mask_d;
         spike_group_q <= spike_group_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d       = state_q;
      addr_d        = addr_q;
      pre_cnt_d     = pre_cnt_q;
      grp_d         = grp_q;
      tstep_pend_d  = tstep_pend_q | bus.tstep_req;
      tref_pend_d   = tref_pend_q | bus.tref_req;
      spike_valid_d = capture;
      spike_mask_d  = capture ? bus.neur_event_out : spike_mask_q;
      spike_group_d = capture ? grp_q : spike_group_q;
      case (state_q)
         S_IDLE: begin
            // A pulse landing on the start edge is absorbed: the flag is simply cleared.
            if (tref_pend_q) begin
               state_d     = S_TR_PRE;
               tref_pend_d = 1'b0;
               pre_cnt_d   = '0;
            end else if (tstep_pend_q) begin
               state_d      = S_TS_RD;
               tstep_pend_d = 1'b0;
               grp_d        = '0;
            end else if (bus.aer_valid && aer_ready) begin
               state_d = S_PRE_RD;
               addr_d  = bus.aer_addr;
               grp_d   = '0;
            end
         end
         S_PRE_RD:  state_d = S_PRE_WR;
         S_PRE_WR:  state_d = S_POST_RD;
         S_POST_RD: state_d = S_POST_WR;
         S_TS_RD:   state_d = S_TS_WR;
         S_TR_RD:   state_d = S_TR_WR;
         S_TR_PRE: begin
            pre_cnt_d = pre_cnt_q + PRE_NEUR_ADDR_WIDTH'(1);
            if (last_pre) begin
               state_d   = S_TR_RD;
               pre_cnt_d = '0;
               grp_d     = '0;
            end
         end
         S_POST_WR, S_TS_WR, S_TR_WR: begin
            // Single pass over the groups: the last write returns to IDLE instead of wrapping.
            if (last_grp) begin
               state_d = S_IDLE;
               grp_d   = '0;
            end else begin
               grp_d   = grp_q + GW'(1);
               state_d = (state_q == S_POST_WR) ? S_POST_RD :
                         (state_q == S_TS_WR)   ? S_TS_RD : S_TR_RD;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Output decode
   always_comb begin
      bus.aer_ready                = aer_ready;
      bus.busy                     = (state_q != S_IDLE);
      bus.ctrl_pre_neuron_address  = '0;
      bus.ctrl_pre_neur_cs         = 1'b0;
      bus.ctrl_pre_neur_we         = 1'b0;
      bus.ctrl_pre_cnt_en          = 1'b0;
      bus.ctrl_post_neur_cs        = 1'b0;
      bus.ctrl_post_neur_we        = 1'b0;
      bus.ctrl_neur_event          = 1'b0;
      bus.ctrl_tstep_event         = 1'b0;
      bus.ctrl_tref_event          = 1'b0;
      // One SRAM word holds POST_NEUR_PARALLEL neurons, so the word index sits above the lane bits.
      bus.ctrl_post_neuron_address = POST_NEUR_ADDR_WIDTH'({grp_q, {BW{1'b0}}});
      bus.syn_addr                 = SYN_ARRAY_ADDR_WIDTH'(addr_q) * SYN_ARRAY_ADDR_WIDTH'(GROUPS)
                                     + SYN_ARRAY_ADDR_WIDTH'(grp_q);
      bus.spike_valid              = spike_valid_q;
      bus.spike_mask               = spike_mask_q;
      bus.spike_group              = spike_group_q;
      case (state_q)
         S_PRE_RD: begin
            bus.ctrl_pre_neuron_address = addr_q;
            bus.ctrl_pre_neur_cs        = 1'b1;
         end
         S_PRE_WR: begin
            bus.ctrl_pre_neuron_address = addr_q;
            bus.ctrl_pre_neur_cs        = 1'b1;
            bus.ctrl_pre_neur_we        = 1'b1;
            bus.ctrl_pre_cnt_en         = 1'b1;
         end
         S_POST_RD: bus.ctrl_post_neur_cs = 1'b1;
         S_POST_WR: begin
            bus.ctrl_post_neur_cs = 1'b1;
            bus.ctrl_post_neur_we = 1'b1;
            bus.ctrl_neur_event   = 1'b1;
         end
         S_TS_RD: begin
            bus.ctrl_post_neur_cs = 1'b1;
            bus.ctrl_tstep_event  = 1'b1;
         end
         S_TS_WR: begin
            bus.ctrl_post_neur_cs = 1'b1;
            bus.ctrl_post_neur_we = 1'b1;
            bus.ctrl_tstep_event  = 1'b1;
         end
         S_TR_PRE: begin
            bus.ctrl_pre_neuron_address = pre_cnt_q;
            bus.ctrl_pre_neur_cs        = 1'b1;
            bus.ctrl_pre_neur_we        = 1'b1;
            bus.ctrl_tref_event         = 1'b1;
         end
         S_TR_RD: begin
            bus.ctrl_post_neur_cs = 1'b1;
            bus.ctrl_tref_event   = 1'b1;
         end
         S_TR_WR: begin
            bus.ctrl_post_neur_cs = 1'b1;
            bus.ctrl_post_neur_we = 1'b1;
            bus.ctrl_tref_event   = 1'b1;
         end
         default: ;
      endcase
   end
endmodule

// File: tb/tb_neuron_event_scheduler.sv
// Purpose : directed self-checking bench for neuron_event_scheduler.
// Latency : samples 1 time unit after each rising edge; fixed-length steps, no open-ended waits.
// Backpressure: drives aer_valid/aer_addr and request pulses; checks aer_ready against hand-computed values.
module tb_neuron_event_scheduler;
   logic clk = 1'b0;
   logic rst_n;
   int   n_chk  = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   neuron_event_scheduler_if bus ();

   neuron_event_scheduler dut (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .bus     (bus)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Entered at the PRE_RD sample of an AER sweep; leaves at the IDLE sample after it.
   task automatic aer_sweep(input int a);
      chk("pre_rd_cs", bus.ctrl_pre_neur_cs, 1);
      chk("pre_rd_we", bus.ctrl_pre_neur_we, 0);
      chk("pre_rd_addr", bus.ctrl_pre_neuron_address, a);
      chk("pre_rd_busy", bus.busy, 1);
      tick();
      bus.tstep_req = 1'b0;
      bus.tref_req  = 1'b0;
      chk("pre_wr_we", bus.ctrl_pre_neur_we, 1);
      chk("pre_wr_cnt_en", bus.ctrl_pre_cnt_en, 1);
      chk("pre_wr_addr", bus.ctrl_pre_neuron_address, a);
      tick();
      for (int g = 0; g < 64; g++) begin
         chk("post_rd_cs", bus.ctrl_post_neur_cs, 1);
         chk("post_rd_we", bus.ctrl_post_neur_we, 0);
         chk("post_rd_pre_cs", bus.ctrl_pre_neur_cs, 0);
         chk("syn_addr", bus.syn_addr, a * 64 + g);
         chk("post_addr", bus.ctrl_post_neuron_address, g * 4);
         chk("aer_ready_busy", bus.aer_ready, 0);
         tick();
         chk("post_wr_we", bus.ctrl_post_neur_we, 1);
         chk("post_wr_neur_event", bus.ctrl_neur_event, 1);
         chk("post_wr_busy", bus.busy, 1);
         tick();
      end
      chk("aer_end_busy", bus.busy, 0);
   endtask

   // Entered at the first TS_RD sample; injects spikes at groups 20 and 63.
   task automatic ts_sweep();
      for (int g = 0; g < 64; g++) begin
         tick_check_ts_rd(g);
         tick();
         bus.tstep_req = 1'b0;
         bus.tref_req  = 1'b0;
         chk("ts_wr_event", bus.ctrl_tstep_event, 1);
         chk("ts_wr_we", bus.ctrl_post_neur_we, 1);
         chk("ts_wr_neur_event", bus.ctrl_neur_event, 0);
         if (g == 21) chk("spike_one_cycle", bus.spike_valid, 0);
         if (g == 20) bus.neur_event_out = 4'b0110;
         if (g == 63) bus.neur_event_out = 4'b1010;
         tick();
         bus.neur_event_out = 4'b0000;
      end
      chk("ts_end_busy", bus.busy, 0);
      chk("ts_spike_valid", bus.spike_valid, 1);
      chk("ts_spike_group", bus.spike_group, 63);
      chk("ts_spike_mask", bus.spike_mask, 4'b1010);
   endtask

   task automatic tick_check_ts_rd(input int g);
      chk("ts_rd_event", bus.ctrl_tstep_event, 1);
      chk("ts_rd_cs", bus.ctrl_post_neur_cs, 1);
      chk("ts_rd_we", bus.ctrl_post_neur_we, 0);
      chk("ts_rd_pre_cs", bus.ctrl_pre_neur_cs, 0);
      if (g == 0) chk("ts_no_early_spike", bus.spike_valid, 0);
      if (g == 21) begin
         chk("mid_spike_valid", bus.spike_valid, 1);
         chk("mid_spike_group", bus.spike_group, 20);
         chk("mid_spike_mask", bus.spike_mask, 4'b0110);
      end
   endtask

   // Entered at the first TR_PRE sample; core flags held all-ones to prove nothing is captured.
   task automatic tref_sweep();
      bus.neur_event_out = 4'b1111;
      for (int i = 0; i < 784; i++) begin
         chk("tr_pre_cs", bus.ctrl_pre_neur_cs, 1);
         chk("tr_pre_we", bus.ctrl_pre_neur_we, 1);
         chk("tr_pre_event", bus.ctrl_tref_event, 1);
         chk("tr_pre_addr", bus.ctrl_pre_neuron_address, i);
         chk("tr_pre_cnt_en", bus.ctrl_pre_cnt_en, 0);
         chk("tr_pre_post_cs", bus.ctrl_post_neur_cs, 0);
         tick();
         bus.tstep_req = 1'b0;
         bus.tref_req  = 1'b0;
      end
      for (int g = 0; g < 64; g++) begin
         chk("tr_rd_cs", bus.ctrl_post_neur_cs, 1);
         chk("tr_rd_we", bus.ctrl_post_neur_we, 0);
         chk("tr_rd_event", bus.ctrl_tref_event, 1);
         chk("tr_rd_pre_cs", bus.ctrl_pre_neur_cs, 0);
         chk("tr_rd_tstep", bus.ctrl_tstep_event, 0);
         chk("tr_no_spike_rd", bus.spike_valid, 0);
         tick();
         chk("tr_wr_we", bus.ctrl_post_neur_we, 1);
         chk("tr_wr_event", bus.ctrl_tref_event, 1);
         chk("tr_wr_neur_event", bus.ctrl_neur_event, 0);
         chk("tr_no_spike_wr", bus.spike_valid, 0);
         tick();
      end
      chk("tr_end_busy", bus.busy, 0);
      chk("tr_end_no_spike", bus.spike_valid, 0);
      bus.neur_event_out = 4'b0000;
   endtask

   initial begin
      rst_n              = 1'b0;
      bus.aer_valid      = 1'b1;
      bus.aer_addr       = 10'd5;
      bus.tstep_req      = 1'b0;
      bus.tref_req       = 1'b0;
      bus.neur_event_out = 4'b0000;

      // Reset held with a spike waiting
      tick();
      tick();
      chk("rst_busy", bus.busy, 0);
      chk("rst_aer_ready", bus.aer_ready, 0);
      chk("rst_pre_cs", bus.ctrl_pre_neur_cs, 0);
      chk("rst_post_cs", bus.ctrl_post_neur_cs, 0);
      chk("rst_syn_addr", bus.syn_addr, 0);
      chk("rst_spike_valid", bus.spike_valid, 0);
      chk("rst_tref_event", bus.ctrl_tref_event, 0);
      rst_n = 1'b1;
      tick();
      chk("post_rst_ready", bus.aer_ready, 1);
      chk("post_rst_busy", bus.busy, 0);
      tick();

      // AER 5 accepted; queue AER 0 and pulse TSTEP during the sweep
      bus.aer_addr  = 10'd0;
      bus.tstep_req = 1'b1;
      aer_sweep(5);
      chk("pend_blocks_ready", bus.aer_ready, 0);
      tick();
      ts_sweep();
      chk("ready_after_ts", bus.aer_ready, 1);

      // Queued AER 0, then 783 held back-to-back
      tick();
      chk("spike_cleared", bus.spike_valid, 0);
      bus.aer_addr = 10'd783;
      aer_sweep(0);
      chk("ready_between", bus.aer_ready, 1);
      tick();
      bus.aer_valid = 1'b0;
      aer_sweep(783);

      // TREF and TSTEP in the same cycle: TREF first
      bus.tref_req  = 1'b1;
      bus.tstep_req = 1'b1;
      tick();
      bus.tref_req  = 1'b0;
      bus.tstep_req = 1'b0;
      chk("both_pend_busy", bus.busy, 0);
      chk("both_pend_ready", bus.aer_ready, 0);
      tick();
      bus.tstep_req = 1'b1; // repeat pulse while pending
      tref_sweep();
      chk("ts_pend_after_tref", bus.aer_ready, 0);
      tick();
      ts_sweep();
      tick();
      chk("no_second_tstep", bus.busy, 0);
      chk("idle_ready", bus.aer_ready, 1);

      // Reset in the middle of an AER sweep
      bus.aer_valid = 1'b1;
      bus.aer_addr  = 10'd7;
      tick();
      bus.aer_valid = 1'b0;
      chk("abort_pre_rd_addr", bus.ctrl_pre_neuron_address, 7);
      tick();
      tick();
      chk("abort_in_post", bus.ctrl_post_neur_cs, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("abort_busy", bus.busy, 0);
      chk("abort_post_cs", bus.ctrl_post_neur_cs, 0);
      chk("abort_syn_addr", bus.syn_addr, 0);
      tick();
      chk("abort_no_write", bus.ctrl_post_neur_we, 0);
      rst_n = 1'b1;
      tick();
      chk("abort_idle_busy", bus.busy, 0);
      chk("abort_idle_ready", bus.aer_ready, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
